// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, PC step, FSM states
// and the buffered {pc, instr} entry layout.
package fetch_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned FETCH_BUF_DEPTH = 2;
    localparam logic [XLEN-1:0] PC_STEP     = 32'd4;
    localparam logic [XLEN-1:0] NOP_ENC     = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instr} FIFO between the imem response path and the decode
// output register; flush empties it in one cycle.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t entries [FETCH_BUF_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == 2'(FETCH_BUF_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = entries[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    // Payload needs no reset: it is only read while count says it is valid.
    always_ff @(posedge clock) begin
        if (do_push) entries[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC and single-outstanding imem request FSM, two-entry
// response buffer, and the registered {instruction, pc, valid} handed to decode.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_ENC,
    parameter int unsigned BUF_DEPTH = FETCH_BUF_DEPTH
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] fetch_pc, fetch_pc_next;
    logic            drop, drop_next;
    logic            space;

    logic            buf_push, buf_pop, buf_flush;
    logic            buf_full, buf_empty;
    logic [1:0]      buf_count;
    fetch_entry_t    buf_in, buf_head;

    fetch_buffer u_buffer (
        .clock      (clock),
        .reset      (reset),
        .push       (buf_push),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .push_entry (buf_in),
        .head       (buf_head),
        .count      (buf_count),
        .full       (buf_full),
        .empty      (buf_empty)
    );

    assign imem_req_addr = fetch_pc;
    assign space         = (buf_count < DEPTH);
    assign buf_in.pc     = fetch_pc - PC_STEP;
    assign buf_in.instr  = imem_resp_data;
    assign buf_flush     = redirect_valid;
    assign buf_pop       = !stall && !buf_empty && !redirect_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            drop     <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            drop     <= drop_next;
        end
    end

    always_comb begin
        state_next     = state;
        fetch_pc_next  = fetch_pc;
        drop_next      = drop;
        imem_req_valid = 1'b0;
        buf_push       = 1'b0;

        case (state)
            S_IDLE: state_next = S_REQ;
            S_REQ: begin
                imem_req_valid = space && !redirect_valid;
                if (imem_req_valid && imem_req_ready) begin
                    fetch_pc_next = fetch_pc + PC_STEP;
                    state_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    buf_push   = !drop && !redirect_valid;
                    drop_next  = 1'b0;
                    state_next = S_REQ;
                end
            end
            default: state_next = S_IDLE;
        endcase

        // A redirect while a response is still owed keeps waiting for it, marked stale.
        if (redirect_valid) begin
            fetch_pc_next = align_pc(redirect_pc);
            if (state == S_WAIT && !imem_resp_valid) begin
                drop_next  = 1'b1;
                state_next = S_WAIT;
            end else begin
                drop_next  = 1'b0;
                state_next = S_REQ;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instruction <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else if (redirect_valid) begin
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else if (!stall) begin
            if (!buf_empty) begin
                instruction <= buf_head.instr;
                instr_pc    <= buf_head.pc;
                instr_valid <= 1'b1;
            end else begin
                instruction <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
        end
    end

    resp_only_in_wait: assert property (@(posedge clock) disable iff (reset)
        imem_resp_valid |-> state == S_WAIT);

    no_push_when_full: assert property (@(posedge clock) disable iff (reset)
        !(buf_push && buf_full));

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for the fetch stage: a small imem model answers requests, the
// stimulus queues the expected decode stream, and a monitor checks each consumed word.
module tb_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] hs_q[$];
    logic [31:0] last_hs = '0;
    int          resp_lat = 1;
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP),
        .BUF_DEPTH (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instruction     (instruction),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0020_81B3;
            32'h0000_0004: return 32'h0000_0013;
            default:       return a ^ 32'hC0DE_0000;
        endcase
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%08h required=%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_run(input logic [31:0] start, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.pc    = start + 32'(4 * i);
            e.instr = mem_word(e.pc);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_drain(input string name, input int max);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < max) begin
            tick();
            i++;
        end
        check32(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_queue_le(input string name, input int lim, input int max);
        int i;
        i = 0;
        while (exp_q.size() > lim && i < max) begin
            tick();
            i++;
        end
        check32(name, {31'b0, exp_q.size() <= lim}, 32'd1);
    endtask

    task automatic wait_hs(input string name, input int n, input int max);
        int i;
        i = 0;
        while (hs_q.size() < n && i < max) begin
            tick();
            i++;
        end
        check32(name, {31'b0, hs_q.size() >= n}, 32'd1);
    endtask

    // Called just after a rising edge; stall masks the redirect cycle from the monitor.
    task automatic do_redirect(input logic [31:0] pc);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        exp_q.delete();
        hs_q.delete();
        tick();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        check32("redirect_instr", instruction, NOP);
        check32("redirect_valid", {31'b0, instr_valid}, 32'd0);
    endtask

    // Instruction memory model: records each accepted request and answers once.
    initial begin : imem_model
        logic [31:0] a;
        int          d;
        forever begin
            @(negedge clock);
            if (!reset && imem_req_valid && imem_req_ready) begin
                a       = imem_req_addr;
                d       = resp_lat;
                last_hs = a;
                hs_q.push_back(a);
                @(posedge clock);
                repeat (d - 1) @(posedge clock);
                #1;
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(a);
                @(posedge clock);
                #1;
                imem_resp_valid = 1'b0;
            end
        end
    end

    // Decode-side monitor: a word is consumed when valid and not stalled.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (!reset) begin
            if (instr_valid && !stall) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_instr: actual pc=%08h instr=%08h required no instruction",
                             instr_pc, instruction);
                end else begin
                    e = exp_q.pop_front();
                    check32("instr_pc", instr_pc, e.pc);
                    check32("instruction", instruction, e.instr);
                end
            end else if (!instr_valid) begin
                check32("bubble_nop", instruction, NOP);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] h_instr, h_pc, exp_addr;
        logic        h_valid;
        int          n0;

        // Power-on reset
        reset = 1'b1;
        repeat (3) tick();
        check32("rst_instr", instruction, NOP);
        check32("rst_pc", instr_pc, 32'd0);
        check32("rst_valid", {31'b0, instr_valid}, 32'd0);
        check32("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        push_run(32'h0, 16);
        reset = 1'b0;
        @(negedge clock);
        check32("idle_req_valid", {31'b0, imem_req_valid}, 32'd0);
        @(negedge clock);
        check32("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check32("first_req_addr", imem_req_addr, 32'h0);
        tick();

        // Streaming: sequential addresses
        wait_hs("stream_hs", 3, 50);
        check32("stream_addr0", hs_q[0], 32'h0);
        check32("stream_addr1", hs_q[1], 32'h4);
        check32("stream_addr2", hs_q[2], 32'h8);

        // Decode stall: outputs hold, buffer fills, requests stop
        wait_queue_le("pre_stall", 12, 100);
        stall   = 1'b1;
        h_instr = instruction;
        h_pc    = instr_pc;
        h_valid = instr_valid;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check32("stall_hold_instr", instruction, h_instr);
            check32("stall_hold_pc", instr_pc, h_pc);
            check32("stall_hold_valid", {31'b0, instr_valid}, {31'b0, h_valid});
            if (i == 5) check32("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        end
        tick();
        stall = 1'b0;
        wait_drain("stream_drain", 200);

        // Reset mid-stream takes effect without a clock edge
        reset = 1'b1;
        #1;
        check32("midrst_instr", instruction, NOP);
        check32("midrst_pc", instr_pc, 32'd0);
        check32("midrst_valid", {31'b0, instr_valid}, 32'd0);
        check32("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        exp_q.delete();
        hs_q.delete();
        tick();
        tick();
        push_run(32'h0, 24);
        reset = 1'b0;
        @(negedge clock);
        check32("midrst_idle_req", {31'b0, imem_req_valid}, 32'd0);
        @(negedge clock);
        check32("midrst_first_req", {31'b0, imem_req_valid}, 32'd1);
        check32("midrst_first_addr", imem_req_addr, 32'h0);
        tick();

        // Memory back-pressure: request held stable, one handshake on ready
        wait_queue_le("pre_backpressure", 20, 100);
        imem_req_ready = 1'b0;
        exp_addr = last_hs + 32'd4;
        n0 = hs_q.size();
        begin : find_req
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                if (imem_req_valid) disable find_req;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            check32("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
            check32("bp_req_addr", imem_req_addr, exp_addr);
            check32("bp_no_handshake", 32'(hs_q.size()), 32'(n0));
        end
        tick();
        imem_req_ready = 1'b1;
        @(negedge clock);
        check32("bp_one_handshake", 32'(hs_q.size()), 32'(n0 + 1));
        check32("bp_handshake_addr", last_hs, exp_addr);
        tick();

        // Redirect while waiting; the late response must be discarded
        resp_lat = 2;
        n0 = hs_q.size();
        begin : find_hs
            for (int i = 0; i < 20; i++) begin
                tick();
                if (hs_q.size() > n0) disable find_hs;
            end
        end
        check32("redir_wait_hs", {31'b0, hs_q.size() > n0}, 32'd1);
        do_redirect(32'h0000_0100);
        resp_lat = 1;
        push_run(32'h0000_0100, 8);
        wait_hs("redir_hs", 1, 50);
        check32("redir_addr", hs_q[0], 32'h0000_0100);
        wait_drain("redir_drain", 200);

        // Redirect with unaligned PC at the top of the address space, then wrap
        do_redirect(32'hFFFF_FFFF);
        push_run(32'hFFFF_FFFC, 4);
        wait_hs("wrap_hs", 2, 50);
        check32("wrap_addr0", hs_q[0], 32'hFFFF_FFFC);
        check32("wrap_addr1", hs_q[1], 32'h0000_0000);
        wait_drain("wrap_drain", 200);

        stall = 1'b1;
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
